// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the CPU / loader memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_CPU     = 2'd0,
    ARB_LD_ACC  = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  localparam logic [15:0] RAM_BASE  = 16'h0000;
  localparam logic [15:0] ROM_BASE  = 16'hFE00;
  localparam int          ARB_CNT_W = 4;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [ARB_CNT_W-1:0] sat_inc(input logic [ARB_CNT_W-1:0] v,
                                                   input logic [ARB_CNT_W-1:0] lim);
    return (v >= lim) ? v : v + ARB_CNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU, loader and memory-map signal bundle; master is the arbiter, slave the surroundings.
interface mem_port_arbiter_if;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rnw;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;

  logic        ld_req;
  logic        ld_we;
  logic [15:0] ld_addr;
  logic [7:0]  ld_wdata;
  logic        ld_ack;
  logic        ld_rvalid;
  logic [7:0]  ld_rdata;
  logic        ld_owner;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rnw;
  logic [7:0]  mem_rdata;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_rnw,
    output cpu_rdata, cpu_ready,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_ack, ld_rvalid, ld_rdata, ld_owner,
    output mem_addr, mem_wdata, mem_rnw,
    input  mem_rdata
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_rnw,
    input  cpu_rdata, cpu_ready,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_ack, ld_rvalid, ld_rdata, ld_owner,
    input  mem_addr, mem_wdata, mem_rnw,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_mux.sv
// Combinational owner select of the memory port address, write data and direction.
module mem_port_mux
  import mem_arb_pkg::*;
(
  input  arb_state_t  state_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_wdata_i,
  input  logic        cpu_rnw_i,
  input  logic [15:0] ld_addr_i,
  input  logic [7:0]  ld_wdata_i,
  input  logic        ld_we_i,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic        mem_rnw_o
);

  always_comb begin
    mem_addr_o  = cpu_addr_i;
    mem_wdata_o = cpu_wdata_i;
    mem_rnw_o   = cpu_rnw_i;
    case (state_i)
      ARB_LD_ACC: begin
        mem_addr_o  = ld_addr_i;
        mem_wdata_o = ld_wdata_i;
        mem_rnw_o   = ~ld_we_i;
      end
      // Re-fetch the stalled CPU read so its data is ready when RDY returns.
      ARB_RELEASE: mem_rnw_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Steals memory cycles for the loader by holding CPU ready low; bursts of up to BURST_MAX
// single-cycle accesses, one RELEASE cycle, then at least CPU_SLOT CPU cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int CPU_SLOT  = 2
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.master bus
);

  localparam logic [ARB_CNT_W-1:0] SLOT_LIM  = ARB_CNT_W'(CPU_SLOT);
  localparam logic [ARB_CNT_W-1:0] BURST_LIM = ARB_CNT_W'(BURST_MAX);

  arb_state_t           state_q, state_d;
  logic [ARB_CNT_W-1:0] slot_q, slot_d;
  logic [ARB_CNT_W-1:0] burst_q, burst_d;
  logic [ARB_CNT_W-1:0] slot_inc, burst_inc;
  logic [7:0]           hold_q, hold_d;
  logic                 rvalid_q, rvalid_d;
  logic                 ack;
  logic                 ld_we_qual;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_CPU;
      slot_q   <= '0;
      burst_q  <= '0;
      hold_q   <= 8'h00;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      burst_q  <= burst_d;
      hold_q   <= hold_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    burst_d   = burst_q;
    hold_d    = hold_q;
    ack       = 1'b0;
    slot_inc  = sat_inc(slot_q, SLOT_LIM);
    burst_inc = burst_q + ARB_CNT_W'(1);
    case (state_q)
      ARB_CPU: begin
        slot_d = slot_inc;
        hold_d = bus.mem_rdata;
        // The current cycle counts toward the slot, so a continuous request
        // leaves the CPU exactly CPU_SLOT cycles; CPU writes are never stalled.
        if (bus.ld_req && bus.cpu_rnw && (slot_inc == SLOT_LIM)) begin
          state_d = ARB_LD_ACC;
        end
      end
      ARB_LD_ACC: begin
        ack = bus.ld_req;
        if (ack) begin
          burst_d = burst_inc;
        end
        if (!(bus.ld_req && (burst_inc < BURST_LIM))) begin
          state_d = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        slot_d  = '0;
        burst_d = '0;
        state_d = ARB_CPU;
      end
      default: state_d = ARB_CPU;
    endcase
    rvalid_d = ack;
  end

  // An idle LD_ACC cycle must not turn a stale ld_we into a memory write.
  assign ld_we_qual = bus.ld_we & bus.ld_req;

  mem_port_mux u_mux (
    .state_i     (state_q),
    .cpu_addr_i  (bus.cpu_addr),
    .cpu_wdata_i (bus.cpu_wdata),
    .cpu_rnw_i   (bus.cpu_rnw),
    .ld_addr_i   (bus.ld_addr),
    .ld_wdata_i  (bus.ld_wdata),
    .ld_we_i     (ld_we_qual),
    .mem_addr_o  (bus.mem_addr),
    .mem_wdata_o (bus.mem_wdata),
    .mem_rnw_o   (bus.mem_rnw)
  );

  assign bus.cpu_ready = (state_q == ARB_CPU);
  assign bus.ld_owner  = (state_q == ARB_LD_ACC);
  assign bus.ld_ack    = ack;
  assign bus.ld_rvalid = rvalid_q;
  assign bus.ld_rdata  = bus.mem_rdata;
  assign bus.cpu_rdata = (state_q == ARB_CPU) ? bus.mem_rdata : hold_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a rule-level model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int          BURST_MAX = 4;
  localparam int          CPU_SLOT  = 2;
  localparam logic [15:0] RAM_END   = RAM_BASE + 16'h0200;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] ram_m [512] = '{default: 8'h00};
  logic [7:0] sh_ram [512];

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.BURST_MAX(BURST_MAX), .CPU_SLOT(CPU_SLOT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [15:0] a);
    return a[7:0] ^ {a[8], 7'h25};
  endfunction

  function automatic logic [7:0] mem_peek(input logic [15:0] a);
    if (a < RAM_END) return ram_m[9'(a - RAM_BASE)];
    if (a >= ROM_BASE) return rom_val(a);
    return 8'h00;
  endfunction

  function automatic logic [7:0] sh_peek(input logic [15:0] a);
    if (a < RAM_END) return sh_ram[9'(a - RAM_BASE)];
    if (a >= ROM_BASE) return rom_val(a);
    return 8'h00;
  endfunction

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return RAM_BASE + 16'($urandom_range(0, 31));
    return ROM_BASE + 16'($urandom_range(0, 511));
  endfunction

  // Memory map: synchronous one-cycle read, read-first RAM write.
  always @(posedge clk) begin
    bus.mem_rdata <= mem_peek(bus.mem_addr);
    if (!bus.mem_rnw && bus.mem_addr < RAM_END) ram_m[9'(bus.mem_addr - RAM_BASE)] <= bus.mem_wdata;
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.cpu_addr  = 16'hFF00;
    bus.cpu_wdata = 8'h00;
    bus.cpu_rnw   = 1'b1;
    bus.ld_req    = 1'b0;
    bus.ld_we     = 1'b0;
    bus.ld_addr   = 16'h0000;
    bus.ld_wdata  = 8'h00;
  endtask

  task automatic wait_ack(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (bus.ld_ack === 1'b1) seen = 1'b1;
      else next_cyc();
    end
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    #2;
    checks++;
    if ({bus.cpu_ready, bus.ld_ack, bus.ld_rvalid, bus.ld_owner} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags: got %b want 1000", {bus.cpu_ready, bus.ld_ack, bus.ld_rvalid, bus.ld_owner});
    end
    checks++;
    if (bus.mem_addr !== 16'hFF00) begin
      errors++; $display("FAIL reset_mem_addr: got %h want ff00", bus.mem_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_cpu_only();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.cpu_ready, bus.ld_ack} !== 2'b10 || bus.mem_addr !== 16'hFF00) begin
        errors++; $display("FAIL cpu_only_%0d: ready/ack %b addr %h want 10 ff00", i, {bus.cpu_ready, bus.ld_ack}, bus.mem_addr);
      end
      if (i > 0) begin
        checks++;
        if (bus.cpu_rdata !== rom_val(16'hFF00)) begin
          errors++; $display("FAIL cpu_only_rdata: got %h want %h", bus.cpu_rdata, rom_val(16'hFF00));
        end
      end
      next_cyc();
    end
  endtask

  task automatic test_cpu_write();
    bus.cpu_rnw = 1'b0; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 8'h33;
    bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if ({bus.cpu_ready, bus.ld_ack, bus.mem_rnw} !== 3'b100) begin
      errors++; $display("FAIL cpuwr_no_ack: ready/ack/rnw %b want 100", {bus.cpu_ready, bus.ld_ack, bus.mem_rnw});
    end
    next_cyc();
    bus.cpu_rnw = 1'b1; bus.cpu_addr = 16'hFF01;
    @(negedge clk);
    checks++;
    if ({bus.cpu_ready, bus.ld_ack} !== 2'b10) begin
      errors++; $display("FAIL cpuwr_grant_cycle: ready/ack %b want 10", {bus.cpu_ready, bus.ld_ack});
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if ({bus.ld_ack, bus.ld_owner, bus.cpu_ready} !== 3'b110 || bus.mem_addr !== 16'h0010) begin
      errors++; $display("FAIL cpuwr_ld_ack: ack/own/ready %b addr %h want 110 0010", {bus.ld_ack, bus.ld_owner, bus.cpu_ready}, bus.mem_addr);
    end
    next_cyc();
    bus.ld_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.ld_ack, bus.ld_rvalid} !== 2'b01 || bus.ld_rdata !== 8'h33) begin
      errors++; $display("FAIL cpuwr_ld_rdata: ack/rvalid %b data %h want 01 33", {bus.ld_ack, bus.ld_rvalid}, bus.ld_rdata);
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if ({bus.cpu_ready, bus.ld_owner, bus.mem_rnw} !== 3'b001 || bus.mem_addr !== 16'hFF01) begin
      errors++; $display("FAIL cpuwr_release: ready/own/rnw %b addr %h want 001 ff01", {bus.cpu_ready, bus.ld_owner, bus.mem_rnw}, bus.mem_addr);
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if (bus.cpu_ready !== 1'b1) begin
      errors++; $display("FAIL cpuwr_back_to_cpu: ready %b want 1", bus.cpu_ready);
    end
  endtask

  task automatic test_ld_write_read();
    bit seen;
    next_cyc();
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 16'h0020; bus.ld_wdata = 8'h5A;
    wait_ack(seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL ldwr_grant: no ack within 8 cycles, want ack");
    end
    next_cyc();
    bus.ld_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.ld_ack, bus.ld_rvalid} !== 2'b11) begin
      errors++; $display("FAIL ldwr_second_ack: ack/rvalid %b want 11", {bus.ld_ack, bus.ld_rvalid});
    end
    next_cyc();
    bus.ld_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.ld_ack, bus.ld_rvalid} !== 2'b01 || bus.ld_rdata !== 8'h5A) begin
      errors++; $display("FAIL ldwr_readback: ack/rvalid %b data %h want 01 5a", {bus.ld_ack, bus.ld_rvalid}, bus.ld_rdata);
    end
    set_idle();
    repeat (3) next_cyc();
  endtask

  task automatic test_burst_pattern();
    byte exp_q[$];
    byte obs;
    int  n = 0;
    set_idle();
    repeat (4) next_cyc();
    exp_q.push_back("C");
    while (n < 10) begin
      for (int b = 0; b < BURST_MAX && n < 10; b++) begin
        exp_q.push_back("A");
        n++;
      end
      if (n < 10) begin
        exp_q.push_back("R");
        for (int s = 0; s < CPU_SLOT; s++) exp_q.push_back("C");
      end
    end
    bus.ld_req = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      bus.ld_addr = RAM_BASE + 16'($urandom_range(0, 31));
      @(negedge clk);
      obs = (bus.ld_ack === 1'b1) ? "A" : (bus.cpu_ready === 1'b1) ? "C" : (bus.ld_owner === 1'b0) ? "R" : "?";
      checks++;
      if (obs !== exp_q[i]) begin
        errors++; $display("FAIL burst_pattern_%0d: got %c want %c", i, obs, exp_q[i]);
      end
      next_cyc();
    end
    set_idle();
    repeat (3) next_cyc();
  endtask

  task automatic test_reset_mid_burst();
    bit seen;
    set_idle();
    repeat (3) next_cyc();
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 16'h0030; bus.ld_wdata = 8'hA5;
    wait_ack(seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rst_burst_grant: no ack within 8 cycles, want ack");
    end
    next_cyc();
    bus.ld_addr = 16'h0031; bus.ld_wdata = 8'hC3;
    #1;
    checks++;
    if ({bus.ld_ack, bus.ld_rvalid} !== 2'b11) begin
      errors++; $display("FAIL rst_burst_2nd_ack: ack/rvalid %b want 11", {bus.ld_ack, bus.ld_rvalid});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.cpu_ready, bus.ld_owner, bus.ld_rvalid, bus.ld_ack} !== 4'b1000) begin
      errors++; $display("FAIL rst_burst_flags: ready/own/rvalid/ack %b want 1000", {bus.cpu_ready, bus.ld_owner, bus.ld_rvalid, bus.ld_ack});
    end
    bus.ld_req = 1'b0; bus.ld_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bus.cpu_addr = 16'h0030;
    next_cyc();
    bus.cpu_addr = 16'h0031;
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== 8'hA5) begin
      errors++; $display("FAIL rst_burst_first_write: got %h want a5", bus.cpu_rdata);
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL rst_burst_second_write: got %h want 00", bus.cpu_rdata);
    end
    next_cyc();
  endtask

  task automatic test_ld_drop();
    set_idle();
    bus.cpu_addr = 16'hFF03;
    repeat (3) next_cyc();
    bus.ld_req = 1'b1; bus.ld_addr = 16'h0020;
    @(negedge clk);
    checks++;
    if ({bus.cpu_ready, bus.ld_ack} !== 2'b10 || bus.cpu_rdata !== rom_val(16'hFF03)) begin
      errors++; $display("FAIL drop_grant: ready/ack %b data %h want 10 %h", {bus.cpu_ready, bus.ld_ack}, bus.cpu_rdata, rom_val(16'hFF03));
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if (bus.ld_ack !== 1'b1 || bus.cpu_rdata !== rom_val(16'hFF03)) begin
      errors++; $display("FAIL drop_ack1_hold: ack %b data %h want 1 %h", bus.ld_ack, bus.cpu_rdata, rom_val(16'hFF03));
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if ({bus.ld_ack, bus.ld_rvalid} !== 2'b11 || bus.ld_rdata !== 8'h5A) begin
      errors++; $display("FAIL drop_ack2: ack/rvalid %b data %h want 11 5a", {bus.ld_ack, bus.ld_rvalid}, bus.ld_rdata);
    end
    next_cyc();
    bus.ld_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.ld_ack, bus.ld_owner, bus.ld_rvalid} !== 3'b011 || bus.ld_rdata !== 8'h5A) begin
      errors++; $display("FAIL drop_idle: ack/own/rvalid %b data %h want 011 5a", {bus.ld_ack, bus.ld_owner, bus.ld_rvalid}, bus.ld_rdata);
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if ({bus.cpu_ready, bus.mem_rnw} !== 2'b01 || bus.mem_addr !== 16'hFF03) begin
      errors++; $display("FAIL drop_release: ready/rnw %b addr %h want 01 ff03", {bus.cpu_ready, bus.mem_rnw}, bus.mem_addr);
    end
    next_cyc();
    @(negedge clk);
    checks++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== rom_val(16'hFF03)) begin
      errors++; $display("FAIL drop_cpu_resume: ready %b data %h want 1 %h", bus.cpu_ready, bus.cpu_rdata, rom_val(16'hFF03));
    end
    next_cyc();
  endtask

  // Rule-level model: owner sequence from run lengths, data from a shadow memory.
  task automatic test_random();
    byte        kind, exp_kind = "C";
    bit         have_exp = 1'b0, prev_ack = 1'b0, prev_rd = 1'b0, cpu_ok = 1'b0, last_ready = 1'b1;
    logic [7:0] prev_ld_exp = 8'h00, prev_cpu_exp = 8'h00;
    int         cpu_run = CPU_SLOT, acks = 0;
    for (int i = 0; i < 512; i++) sh_ram[i] = ram_m[i];
    set_idle();
    repeat (3) next_cyc();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (last_ready) begin
        bus.cpu_rnw   = ($urandom_range(0, 3) != 0);
        bus.cpu_addr  = rand_addr();
        bus.cpu_wdata = 8'($urandom);
      end
      bus.ld_req   = ($urandom_range(0, 9) < 7);
      bus.ld_we    = 1'($urandom_range(0, 1));
      bus.ld_addr  = rand_addr();
      bus.ld_wdata = 8'($urandom);
      @(negedge clk);
      kind = (bus.cpu_ready === 1'b1) ? "C" : (bus.ld_owner === 1'b1) ? "L" : "R";
      if (have_exp) begin
        checks++;
        if (kind !== exp_kind) begin
          errors++; $display("FAIL rnd_owner@%0d: got %c want %c", cyc, kind, exp_kind);
        end
      end
      checks++;
      if (bus.ld_rvalid !== prev_ack) begin
        errors++; $display("FAIL rnd_rvalid@%0d: got %b want %b", cyc, bus.ld_rvalid, prev_ack);
      end
      if (prev_rd) begin
        checks++;
        if (bus.ld_rdata !== prev_ld_exp) begin
          errors++; $display("FAIL rnd_ld_rdata@%0d: got %h want %h", cyc, bus.ld_rdata, prev_ld_exp);
        end
      end
      if (cpu_ok && kind == "C") begin
        checks++;
        if (bus.cpu_rdata !== prev_cpu_exp) begin
          errors++; $display("FAIL rnd_cpu_rdata@%0d: got %h want %h", cyc, bus.cpu_rdata, prev_cpu_exp);
        end
      end
      checks++;
      if (kind == "C") begin
        if (bus.mem_addr !== bus.cpu_addr || bus.mem_rnw !== bus.cpu_rnw || bus.ld_ack !== 1'b0) begin
          errors++; $display("FAIL rnd_cpu_port@%0d: addr %h rnw %b ack %b want %h %b 0", cyc, bus.mem_addr, bus.mem_rnw, bus.ld_ack, bus.cpu_addr, bus.cpu_rnw);
        end
      end else if (kind == "L") begin
        if (bus.ld_ack !== bus.ld_req || (bus.ld_req && (bus.mem_addr !== bus.ld_addr || bus.mem_rnw !== ~bus.ld_we))) begin
          errors++; $display("FAIL rnd_ld_port@%0d: ack %b addr %h rnw %b want %b %h %b", cyc, bus.ld_ack, bus.mem_addr, bus.mem_rnw, bus.ld_req, bus.ld_addr, ~bus.ld_we);
        end
      end else begin
        if (bus.mem_addr !== bus.cpu_addr || bus.mem_rnw !== 1'b1 || bus.ld_ack !== 1'b0) begin
          errors++; $display("FAIL rnd_release_port@%0d: addr %h rnw %b ack %b want %h 1 0", cyc, bus.mem_addr, bus.mem_rnw, bus.ld_ack, bus.cpu_addr);
        end
      end
      prev_ack = (kind == "L") && bus.ld_req;
      prev_rd  = prev_ack && !bus.ld_we;
      if (prev_rd) prev_ld_exp = sh_peek(bus.ld_addr);
      cpu_ok = (kind == "R") || (kind == "C" && bus.cpu_rnw);
      if (cpu_ok) prev_cpu_exp = sh_peek(bus.cpu_addr);
      if (kind == "C") begin
        if (!bus.cpu_rnw && bus.cpu_addr < RAM_END) sh_ram[9'(bus.cpu_addr - RAM_BASE)] = bus.cpu_wdata;
        if (cpu_run < 15) cpu_run++;
        acks     = 0;
        exp_kind = (bus.ld_req && bus.cpu_rnw && cpu_run >= CPU_SLOT) ? "L" : "C";
      end else if (kind == "L") begin
        if (bus.ld_req) begin
          acks++;
          if (bus.ld_we && bus.ld_addr < RAM_END) sh_ram[9'(bus.ld_addr - RAM_BASE)] = bus.ld_wdata;
        end
        exp_kind = (bus.ld_req && acks < BURST_MAX) ? "L" : "R";
      end else begin
        cpu_run  = 0;
        exp_kind = "C";
      end
      have_exp   = 1'b1;
      last_ready = (kind == "C");
      next_cyc();
    end
    set_idle();
    repeat (4) next_cyc();
  endtask

  initial begin
    test_reset();
    test_cpu_only();
    test_cpu_write();
    test_ld_write_read();
    test_burst_pattern();
    test_reset_mid_burst();
    test_ld_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-ported memory map (512x8 RAM at 0x0000–0x01FF, 512x8 ROM at 0xFE00–0xFFFF, synchronous one-cycle read) between the 8227 CPU and a UART-side program loader/debug port. It sits between `top8227` and `demo_mapped_io`. It steals memory cycles for the loader by dropping the CPU `ready` input during CPU read cycles, with bounded bursts and a guaranteed CPU slot so neither side starves.

## Interface
- `BURST_MAX`, 4: maximum consecutive loader accesses per grant (1–15).
- `CPU_SLOT`, 2: minimum CPU-owned cycles between loader grants (1–15).

- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high.
- `cpu_addr` in 16: CPU address bus, `{addressBusHigh, addressBusLow}`.
- `cpu_wdata` in 8: CPU data out.
- `cpu_rnw` in 1: CPU read-not-write.
- `cpu_rdata` out 8: data returned to the CPU.
- `cpu_ready` out 1: drives the 8227 `ready` input.
- `ld_req` in 1: loader access request, level.
- `ld_we` in 1: loader write enable, qualified by `ld_req`.
- `ld_addr` in 16: loader address.
- `ld_wdata` in 8: loader write data.
- `ld_ack` out 1: request accepted this cycle; address/data/we sampled.
- `ld_rvalid` out 1: `ld_rdata` valid, one cycle after the accepting `ld_ack` for reads and writes.
- `ld_rdata` out 8: loader read data (`mem_rdata` passthrough).
- `mem_addr` out 16, `mem_wdata` out 8, `mem_rnw` out 1: to the memory map.
- `mem_rdata` in 8: memory map read data.
- `ld_owner` out 1: high while the loader drives the memory port.

## Operation
- States: CPU, LD_ACC, RELEASE.
- CPU:
  - Memory port driven by the CPU signals; `cpu_ready`=1; `cpu_rdata`=`mem_rdata`.
  - Slot counter increments, saturating at `CPU_SLOT`.
  - Goes to LD_ACC when `ld_req` && `cpu_rnw` && slot counter == `CPU_SLOT`.
  - A CPU write cycle (`cpu_rnw`=0) is never interrupted; the loader waits.
- LD_ACC:
  - Memory port driven by `ld_addr`/`ld_wdata`, with `mem_rnw` = `~ld_we`.
  - `ld_owner`=1; `cpu_ready`=0; `ld_ack`=`ld_req`.
  - The burst counter increments on each ack.
  - Stays in LD_ACC while `ld_req` && burst count < `BURST_MAX`; otherwise goes to RELEASE.
  - An idle cycle with `ld_req`=0 gives no ack and goes to RELEASE.
- RELEASE:
  - Memory port driven by `cpu_addr` with `mem_rnw` forced to 1, so the CPU's repeated read is fetched.
  - `cpu_ready`=0; slot and burst counters cleared.
  - Always goes to CPU next cycle.
- `ld_rvalid` is a register: set the cycle after any `ld_ack`, otherwise 0. It may be high in LD_ACC (pipelined back-to-back) or in RELEASE.
- `cpu_rdata` in LD_ACC/RELEASE holds the last value presented in CPU state (registered hold). The CPU has RDY low then and ignores it.
- Memory address decode, chip select and ROM/RAM selection stay in the memory map; this block does no decode.

## Timing
- Reset values: state CPU, `cpu_ready`=1, `ld_ack`=0, `ld_rvalid`=0, `ld_owner`=0, `cpu_rdata` hold=0x00, slot counter=0, burst counter=0.
- After reset, the loader waits at least `CPU_SLOT` cycles.
- Grant latency with an idle slot counter: `ld_req` sampled high in CPU → LD_ACC next cycle.
- Throughput: one loader access per cycle. Data for the access acked in cycle N is on `ld_rdata` in cycle N+1.
- Per grant: at most `BURST_MAX` acks, then exactly one RELEASE cycle, then ≥`CPU_SLOT` CPU cycles.
- If `ld_req` is held continuously, the CPU duty is `CPU_SLOT`/(`CPU_SLOT`+`BURST_MAX`+1).
- `ld_req` deasserting mid-burst ends the grant; no ack that cycle.
- `reset` mid-burst: state goes to CPU immediately. Pending `ld_rvalid` is dropped; a write already clocked into RAM stays.
- Counter widths are 4 bits. Comparisons are unsigned; the slot counter saturates and never wraps.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum {ARB_CPU, ARB_LD_ACC, ARB_RELEASE}.
  - Address constants `RAM_BASE` 0x0000 and `ROM_BASE` 0xFE00.
  - `ARB_CNT_W` = 4.
- One sub-module, `mem_port_mux`: purely combinational owner-select of address, wdata and rnw.
- FSM, counters and data-hold registers live in the top of the block.

## Test plan
- Reset, then `ld_req`=0 with the CPU reading 0xFF00 → `cpu_ready`=1 throughout; `mem_addr`=0xFF00; `ld_ack`=0.
- CPU write to 0x0010 while `ld_req` is raised → no ack during the write cycle; grant follows the next CPU read cycle.
- Loader writes 0x5A to 0x0020, then reads 0x0020 → ack, ack; `ld_rvalid` with `ld_rdata`=0x5A on the cycle after the second ack.
- `ld_req` held for 10 accesses with `BURST_MAX`=4 and `CPU_SLOT`=2 → pattern 4 acks, 1 RELEASE, 2 `cpu_ready` cycles, repeating.
- `reset` asserted during the 2nd ack of a burst → `cpu_ready`=1, `ld_owner`=0 and `ld_rvalid`=0 immediately; the 1st write is present in RAM.
- `ld_req` drops after 2 acks → RELEASE, CPU; the CPU resumes its stalled read of 0xFF03 and receives the ROM byte.
